// File: rtl/rv32_pc_unit.sv
// rv32_pc_unit: fetch-stage program counter for the rv32 core.
// Holds the fetch PC, steps it sequentially, and takes trap vectors and
// branch/jump redirects. A redirect that arrives while fetch is stalled is
// parked in a one-entry pending slot and applied once the stall lifts.
// Targets are aligned on load, and misaligned redirect targets are flagged.
// Optional feature macro: RV32_PC_COMPRESSED_EN adds the compressed_i port,
// selects a 2- or 4-byte step and relaxes alignment to 16 bits.
module rv32_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              ALIGN_CHECK  = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
`ifdef RV32_PC_COMPRESSED_EN
    input  logic            compressed_i,
`endif
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            pc_valid_o,
    output logic            misalign_o
);

    // Address bits that must be zero for a legal fetch target.
`ifdef RV32_PC_COMPRESSED_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b0}}, 1'b1};
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b0}}, 2'b11};
`endif

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            mis_q, mis_d;
    logic            pend_v_q, pend_v_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pend_mis_q, pend_mis_d;

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] redir_aligned;
    logic            redir_mis;

    // Sequential increment: 4 bytes, or 2 for a compressed instruction.
    always_comb begin
`ifdef RV32_PC_COMPRESSED_EN
        step = compressed_i ? XLEN'(2) : XLEN'(4);
`else
        step = XLEN'(4);
`endif
    end

    assign pc_plus_o     = pc_q + step;
    assign redir_aligned = redirect_pc_i & ~ALIGN_MASK;
    assign redir_mis     = ALIGN_CHECK && ((redirect_pc_i & ALIGN_MASK) != '0);

    // Next-PC selection: trap > redirect (park if stalled) > pending > stall > step.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        pc_d       = pc_q;
        valid_d    = 1'b1;
        mis_d      = 1'b0;
        pend_v_d   = pend_v_q;
        pend_pc_d  = pend_pc_q;
        pend_mis_d = pend_mis_q;

        if (!valid_q) begin
            // First edge out of reset: fetch RESET_VECTOR, ignore all strobes.
            pc_d = pc_q;
        end else if (trap_i) begin
            pc_d     = trap_vec_i & ~ALIGN_MASK;
            pend_v_d = 1'b0;
        end else if (redirect_i && stall_i) begin
            // Misalignment is judged now and reported when the entry is applied.
            pend_pc_d  = redir_aligned;
            pend_mis_d = redir_mis;
            pend_v_d   = 1'b1;
        end else if (redirect_i) begin
            pc_d     = redir_aligned;
            mis_d    = redir_mis;
            pend_v_d = 1'b0;
        end else if (pend_v_q && !stall_i) begin
            pc_d     = pend_pc_q;
            mis_d    = pend_mis_q;
            pend_v_d = 1'b0;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus_o;
        end
    end

    // State registers; reset also empties the pending slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_pc_q  <= '0;
            pend_mis_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            mis_q      <= mis_d;
            pend_v_q   <= pend_v_d;
            pend_pc_q  <= pend_pc_d;
            pend_mis_q <= pend_mis_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign misalign_o = mis_q;

endmodule

// File: tb/tb_rv32_pc_unit.sv
// Self-checking bench for rv32_pc_unit. Two instances share the stimulus:
// one with ALIGN_CHECK=1 and one with ALIGN_CHECK=0. Expected values are
// queued when a cycle is driven and popped by a monitor after the edge.
module tb_rv32_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic [31:0] trap_vec_i;
    logic        comp;
    logic [31:0] pc_o, pc_plus_o, pc_b, pc_plus_b;
    logic        pc_valid_o, misalign_o, valid_b, mis_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] plus;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

`ifdef RV32_PC_COMPRESSED_EN
    localparam logic [31:0] MIS_TGT  = 32'h41;
    localparam logic [31:0] MIS_EXP  = 32'h40;
    localparam logic [31:0] TRAP_EXP = 32'h122;
`else
    localparam logic [31:0] MIS_TGT  = 32'h42;
    localparam logic [31:0] MIS_EXP  = 32'h40;
    localparam logic [31:0] TRAP_EXP = 32'h120;
`endif

    rv32_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .ALIGN_CHECK(1'b1)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .trap_i        (trap_i),
        .trap_vec_i    (trap_vec_i),
`ifdef RV32_PC_COMPRESSED_EN
        .compressed_i  (comp),
`endif
        .pc_o          (pc_o),
        .pc_plus_o     (pc_plus_o),
        .pc_valid_o    (pc_valid_o),
        .misalign_o    (misalign_o)
    );

    rv32_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .ALIGN_CHECK(1'b0)) u_dut_nochk (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .trap_i        (trap_i),
        .trap_vec_i    (trap_vec_i),
`ifdef RV32_PC_COMPRESSED_EN
        .compressed_i  (comp),
`endif
        .pc_o          (pc_b),
        .pc_plus_o     (pc_plus_b),
        .pc_valid_o    (valid_b),
        .misalign_o    (mis_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: pop one expectation per edge, compare 1 time unit later.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc_o !== e.pc) begin
                errors++;
                $display("FAIL %s pc_o got %h want %h", e.name, pc_o, e.pc);
            end
            checks++;
            if (pc_plus_o !== e.plus) begin
                errors++;
                $display("FAIL %s pc_plus_o got %h want %h", e.name, pc_plus_o, e.plus);
            end
            checks++;
            if (pc_valid_o !== e.valid) begin
                errors++;
                $display("FAIL %s pc_valid_o got %b want %b", e.name, pc_valid_o, e.valid);
            end
            checks++;
            if (misalign_o !== e.mis) begin
                errors++;
                $display("FAIL %s misalign_o got %b want %b", e.name, misalign_o, e.mis);
            end
            checks++;
            if (pc_b !== e.pc || mis_b !== 1'b0) begin
                errors++;
                $display("FAIL %s nochk pc/mis got %h/%b want %h/0", e.name, pc_b, mis_b, e.pc);
            end
        end
    end

    // Drive one cycle of inputs, queue the expected post-edge outputs, advance past the edge.
    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic tr, input logic [31:0] tv,
                         input logic [31:0] epc, input logic ev, input logic emis,
                         input string name);
        exp_t e;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        trap_i        = tr;
        trap_vec_i    = tv;
        e.name  = name;
        e.pc    = epc;
        e.plus  = epc + (comp ? 32'd2 : 32'd4);
        e.valid = ev;
        e.mis   = emis;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic [31:0] epc, input logic emis, input string name);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, epc, 1'b1, emis, name);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc/valid/mis got %h/%b/%b want 0/0/0",
                     pc_o, pc_valid_o, misalign_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(32'h0,  1'b0, "seq_first");
        idle(32'h4,  1'b0, "seq_4");
        idle(32'h8,  1'b0, "seq_8");
        idle(32'hC,  1'b0, "seq_c");
        idle(32'h10, 1'b0, "seq_10");
    endtask

    task automatic test_stall_pending;
        drive(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 32'h10, 1'b1, 1'b0, "stall_capture");
        drive(1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h10, 1'b1, 1'b0, "stall_hold1");
        drive(1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h10, 1'b1, 1'b0, "stall_hold2");
        idle(32'h80, 1'b0, "pend_apply");
        idle(32'h84, 1'b0, "pend_after");
        // A newer parked redirect replaces the older one.
        drive(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 32'h84, 1'b1, 1'b0, "pend_first");
        drive(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 32'h84, 1'b1, 1'b0, "pend_overwrite");
        idle(32'h400, 1'b0, "pend_newest");
        // A live redirect beats an older parked one and discards it.
        drive(1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 32'h400, 1'b1, 1'b0, "pend_old");
        drive(1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 32'h600, 1'b1, 1'b0, "redir_beats_pend");
        idle(32'h604, 1'b0, "pend_dropped");
    endtask

    task automatic test_priority;
        drive(1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h604, 1'b1, 1'b0, "prio_park");
        drive(1'b1, 1'b1, 32'h40,  1'b1, 32'h100, 32'h100, 1'b1, 1'b0, "trap_wins");
        idle(32'h104, 1'b0, "trap_cleared_pend");
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h123, TRAP_EXP, 1'b1, 1'b0, "trap_aligned");
    endtask

    task automatic test_misalign;
        drive(1'b0, 1'b1, MIS_TGT, 1'b0, 32'h0, MIS_EXP, 1'b1, 1'b1, "mis_redirect");
        idle(MIS_EXP + 32'd4, 1'b0, "mis_one_cycle");
        drive(1'b1, 1'b1, 32'h51, 1'b0, 32'h0, MIS_EXP + 32'd4, 1'b1, 1'b0, "mis_park");
        drive(1'b1, 1'b0, 32'h0,  1'b0, 32'h0, MIS_EXP + 32'd4, 1'b1, 1'b0, "mis_park_hold");
        idle(32'h50, 1'b1, "mis_pend_apply");
        idle(32'h54, 1'b0, "mis_pend_after");
    endtask

    task automatic test_wrap;
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, "wrap_top");
        idle(32'h0, 1'b0, "wrap_zero");
    endtask

    task automatic test_async_reset;
        idle(32'h4, 1'b0, "pre_reset");
        drive(1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 32'h4, 1'b1, 1'b0, "pre_reset_park");
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pc/valid/mis got %h/%b/%b want 0/0/0",
                     pc_o, pc_valid_o, misalign_o);
        end
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 32'h900, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "first_edge_ignores");
        idle(32'h4, 1'b0, "reset_cleared_pend");
    endtask

`ifdef RV32_PC_COMPRESSED_EN
    task automatic test_compressed;
        drive(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 32'h20, 1'b1, 1'b0, "c_redirect");
        comp = 1'b1;
        #1;
        checks++;
        if (pc_plus_o !== 32'h22) begin
            errors++;
            $display("FAIL c_plus pc_plus_o got %h want 00000022", pc_plus_o);
        end
        idle(32'h22, 1'b0, "c_step");
        comp = 1'b0;
        drive(1'b0, 1'b1, 32'h31, 1'b0, 32'h0, 32'h30, 1'b1, 1'b1, "c_mis");
    endtask
`endif

    initial begin
        reset_n       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        trap_i        = 1'b0;
        trap_vec_i    = 32'h0;
        comp          = 1'b0;

        test_reset();
        test_stall_pending();
        test_priority();
        test_misalign();
        test_wrap();
        test_async_reset();
`ifdef RV32_PC_COMPRESSED_EN
        test_compressed();
`endif
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
